// File: rtl/shabal_host_ctrl_if.sv
// shabal_host_ctrl_if: host-side and hash-core-side signal bundle of shabal_host_ctrl
interface shabal_host_ctrl_if;
  logic        start;
  logic [7:0]  nblocks;
  logic [31:0] msg_word;
  logic        msg_valid;
  logic        msg_ready;
  logic        init;
  logic        load;
  logic        fetch;
  logic [15:0] idata;
  logic        ack;
  logic [15:0] odata;
  logic [31:0] digest_word;
  logic [2:0]  digest_idx;
  logic        digest_valid;
  logic        busy_o;
  logic        done;
  logic        error;
  modport master (
    output start, nblocks, msg_word, msg_valid, ack, odata,
    input  msg_ready, init, load, fetch, idata, digest_word, digest_idx, digest_valid, busy_o, done, error
  );
  modport slave (
    input  start, nblocks, msg_word, msg_valid, ack, odata,
    output msg_ready, init, load, fetch, idata, digest_word, digest_idx, digest_valid, busy_o, done, error
  );
endinterface

// File: rtl/shabal_host_ctrl.sv
// shabal_host_ctrl: streams message halfwords into a Shabal core and collects the digest, with ack timeout and retry
module shabal_host_ctrl #(
  parameter int RETRY_GAP = 8,
  parameter int MAX_RETRY = 255
) (
  input logic               clk,
  input logic               rst_n,
  shabal_host_ctrl_if.slave bus
);
  localparam int CW = $clog2(RETRY_GAP + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [3:0] {IDLE, INIT, GETW, LOAD_REQ, LOAD_WAIT, GAP, FETCH_REQ, FETCH_WAIT, EMIT, ERR} state_t;
  state_t st, nxt;
  logic [7:0] nb, bc;
  logic [3:0] wc, fc;
  logic [CW-1:0] cyc;
  logic [RW-1:0] rc;
  logic [31:0] w;
  logic [15:0] lo, hi, swp;
  logic hs, fph, err_r, wait_st, tmo, ovf, blk_done;
  assign swp      = {bus.odata[7:0], bus.odata[15:8]};
  assign wait_st  = st == LOAD_WAIT || st == FETCH_WAIT;
  assign tmo      = wait_st && !bus.ack && cyc == CW'(RETRY_GAP - 1);
  assign ovf      = rc == RW'(MAX_RETRY);
  assign blk_done = wc == 4'd15 && bc + 8'd1 == nb;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:       nxt = bus.start ? INIT : IDLE;
      INIT:       nxt = cyc == '0 ? INIT : nb == '0 ? FETCH_REQ : GETW;
      GETW:       nxt = bus.msg_valid ? LOAD_REQ : GETW;
      LOAD_REQ:   nxt = LOAD_WAIT;
      LOAD_WAIT:  nxt = bus.ack ? GAP : tmo ? (ovf ? ERR : LOAD_REQ) : LOAD_WAIT;
      GAP:        nxt = fph ? FETCH_REQ : !hs ? LOAD_REQ : blk_done ? FETCH_REQ : GETW;
      FETCH_REQ:  nxt = FETCH_WAIT;
      FETCH_WAIT: nxt = bus.ack ? (fc[0] ? EMIT : GAP) : tmo ? (ovf ? ERR : FETCH_REQ) : FETCH_WAIT;
      EMIT:       nxt = fc == 4'd15 ? IDLE : GAP;
      default:    nxt = IDLE;
    endcase
  end
  assign bus.msg_ready    = st == GETW;
  assign bus.init         = st == INIT && cyc == '0;
  assign bus.load         = st == LOAD_REQ;
  assign bus.fetch        = st == FETCH_REQ;
  assign bus.idata        = hs ? {w[23:16], w[31:24]} : {w[7:0], w[15:8]};
  assign bus.digest_word  = {hi, lo};
  assign bus.digest_idx   = st == EMIT ? fc[3:1] : 3'd0;
  assign bus.digest_valid = st == EMIT;
  assign bus.busy_o       = st != IDLE;
  assign bus.done         = st == EMIT && fc == 4'd15;
  assign bus.error        = err_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= IDLE;
      nb    <= '0;
      bc    <= '0;
      wc    <= '0;
      fc    <= '0;
      cyc   <= '0;
      rc    <= '0;
      w     <= '0;
      lo    <= '0;
      hi    <= '0;
      hs    <= 1'b0;
      fph   <= 1'b0;
      err_r <= 1'b0;
    end else begin
      st <= nxt;
      if (st == IDLE && bus.start) begin
        nb    <= bus.nblocks;
        bc    <= '0;
        wc    <= '0;
        fc    <= '0;
        cyc   <= '0;
        rc    <= '0;
        hs    <= 1'b0;
        fph   <= 1'b0;
        err_r <= 1'b0;
      end
      if (bus.load || bus.fetch || st == INIT) cyc <= CW'(1);
      else if (wait_st) cyc <= cyc + 1'b1;
      if (wait_st && bus.ack) rc <= '0;
      else if (tmo && !ovf) rc <= rc + 1'b1;
      if (nxt == ERR) err_r <= 1'b1;
      if (nxt == FETCH_REQ) fph <= 1'b1;
      if (st == GETW && bus.msg_valid) begin
        w  <= bus.msg_word;
        hs <= 1'b0;
      end
      if (st == GAP && !fph) begin
        hs <= 1'b1;
        if (hs) begin
          wc <= wc + 4'd1;
          if (wc == 4'd15) bc <= bc + 8'd1;
        end
      end
      if (st == FETCH_WAIT && bus.ack) begin
        if (fc[0]) hi <= swp;
        else begin
          lo <= swp;
          fc <= fc + 4'd1;
        end
      end
      if (st == EMIT) fc <= fc + 4'd1;
    end
endmodule

// File: tb/tb_shabal_host_ctrl.sv
// tb_shabal_host_ctrl: randomized bench checking shabal_host_ctrl against a byte-stream model of host and core
module tb_shabal_host_ctrl;
  localparam int GAP = 8;
  localparam int MAXR = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int tcyc = 0;
  logic [31:0] msg[$];
  logic [31:0] dg[8];
  int g_delay, g_rdrop, g_drop1f, g_noack, g_rst_word;
  shabal_host_ctrl_if bus();
  shabal_host_ctrl #(.RETRY_GAP(GAP), .MAX_RETRY(MAXR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
  endtask
  function automatic logic [15:0] pair(input logic [31:0] v, input int h);
    logic [7:0] a, b;
    a = 8'(v >> (16 * h));
    b = 8'(v >> (16 * h + 8));
    return {a, b};
  endfunction
  task automatic fill(input int nb);
    msg.delete();
    for (int i = 0; i < 16 * nb; i++) msg.push_back($urandom);
    for (int i = 0; i < 8; i++) dg[i] = $urandom;
  endtask
  task automatic chk_rst(input string nm);
    chk({nm, "/ctl"}, {bus.msg_ready, bus.init, bus.load, bus.fetch, bus.digest_valid, bus.busy_o, bus.done, bus.error}, 0);
    chk({nm, "/idata"}, bus.idata, 0);
    chk({nm, "/dword"}, bus.digest_word, 0);
    chk({nm, "/didx"}, bus.digest_idx, 0);
  endtask
  task automatic run_job(input logic [7:0] nb, input string nm);
    int mi = 0, li = 0, fk = 0, di = 0, nload = 0, nfetch = 0, ninit = 0;
    int ack_at = -1, last_st = 0, drops = 0, budget = 0;
    bit prev_drop = 0, prev_sb = 0, pend_f = 0, fin = 0, was_rst = 0;
    bus.nblocks = nb;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.nblocks = 8'($urandom);
    chk({nm, "/start_busy"}, bus.busy_o, 1);
    chk({nm, "/start_err_clr"}, bus.error, 0);
    while (!fin && budget < 20000) begin
      if (bus.init) ninit++;
      if (bus.init | bus.load | bus.fetch) begin
        chk({nm, "/one_strobe"}, $countones({bus.init, bus.load, bus.fetch}), 1);
        chk({nm, "/no_back2back"}, prev_sb, 0);
      end
      prev_sb = bus.init | bus.load | bus.fetch;
      if (bus.load | bus.fetch) begin
        if (prev_drop) chk({nm, "/retry_gap"}, tcyc - last_st, GAP);
        if (bus.load) begin
          nload++;
          chk({nm, "/idata"}, bus.idata, pair(msg[li / 2], li % 2));
        end else nfetch++;
        last_st = tcyc;
        pend_f = bus.fetch;
        prev_drop = g_noack != 0 || (bus.fetch && g_drop1f != 0 && nfetch == 1) ||
                    (g_rdrop != 0 && drops < MAXR && $urandom_range(0, 5) == 0);
        drops = prev_drop ? drops + 1 : 0;
        ack_at = prev_drop ? -1 : tcyc + (g_delay > 0 ? g_delay : int'($urandom_range(1, GAP - 1)));
      end
      if (g_rst_word >= 0 && bus.load && mi == g_rst_word + 1) begin
        rst_n = 1'b0;
        #1;
        chk_rst({nm, "/mid"});
        was_rst = 1;
        fin = 1;
      end
      if (bus.digest_valid) begin
        chk({nm, "/didx"}, bus.digest_idx, di);
        chk({nm, "/dword"}, bus.digest_word, dg[di % 8]);
        di++;
        chk({nm, "/done_last"}, bus.done, di == 8);
      end
      if (bus.done) begin
        chk({nm, "/done_dv"}, bus.digest_valid, 1);
        chk({nm, "/loads"}, li, 32 * int'(nb));
        chk({nm, "/fetches"}, fk, 16);
        chk({nm, "/inits"}, ninit, 1);
        chk({nm, "/ok_expected"}, g_noack, 0);
        fin = 1;
      end
      if (bus.error) begin
        chk({nm, "/err_expected"}, g_noack, 1);
        chk({nm, "/err_loads"}, nload, MAXR + 1);
        chk({nm, "/err_busy"}, bus.busy_o, 1);
        fin = 1;
      end
      if (!fin) begin
        bus.ack = 1'b0;
        bus.odata = 16'($urandom);
        if (tcyc == ack_at) begin
          bus.ack = 1'b1;
          if (pend_f) begin
            bus.odata = pair(dg[(fk / 2) % 8], fk % 2);
            fk++;
          end else begin
            chk({nm, "/idata_hold"}, bus.idata, pair(msg[li / 2], li % 2));
            li++;
          end
          ack_at = -1;
        end else if (bus.msg_ready) bus.ack = 1'($urandom);
        bus.msg_valid = 1'b0;
        bus.msg_word = $urandom;
        if (mi < msg.size() && $urandom_range(0, 3) != 0) begin
          bus.msg_valid = 1'b1;
          bus.msg_word = msg[mi];
          if (bus.msg_ready) mi++;
        end
        tick();
        budget++;
      end
    end
    chk({nm, "/finished"}, fin, 1);
    bus.ack = 1'b0;
    bus.msg_valid = 1'b0;
    if (was_rst) begin
      tick();
      rst_n = 1'b1;
      tick();
      chk({nm, "/post_rst_quiet"}, {bus.init, bus.load, bus.fetch, bus.busy_o}, 0);
    end else begin
      tick();
      chk({nm, "/idle_after"}, bus.busy_o, 0);
      if (g_noack != 0) chk({nm, "/err_sticky"}, bus.error, 1);
    end
  endtask
  initial begin
    int nbr;
    bus.start = 1'b0;
    bus.nblocks = '0;
    bus.msg_word = '0;
    bus.msg_valid = 1'b0;
    bus.ack = 1'b0;
    bus.odata = '0;
    g_delay = 3;
    g_rdrop = 0;
    g_drop1f = 0;
    g_noack = 0;
    g_rst_word = -1;
    repeat (2) tick();
    chk_rst("reset");
    rst_n = 1'b1;
    tick();
    chk("release_quiet", {bus.init, bus.load, bus.fetch, bus.busy_o}, 0);
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back(32'h03020100 + 32'h04040404 * i);
    for (int i = 0; i < 8; i++) dg[i] = $urandom;
    dg[0] = 32'hDEADBEEF;
    run_job(8'd1, "vec");
    g_delay = 0;
    fill(0);
    run_job(8'd0, "empty");
    g_drop1f = 1;
    fill(0);
    run_job(8'd0, "drop_fetch");
    g_drop1f = 0;
    g_noack = 1;
    fill(1);
    run_job(8'd1, "noack");
    g_noack = 0;
    fill(0);
    run_job(8'd0, "err_clear");
    g_rst_word = 5;
    fill(2);
    run_job(8'd2, "mid_rst");
    g_rst_word = -1;
    fill(1);
    run_job(8'd1, "after_rst");
    g_rdrop = 1;
    for (int j = 0; j < 6; j++) begin
      nbr = $urandom_range(0, 2);
      fill(nbr);
      run_job(8'(nbr), "rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
